// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port dmem BRAM among NCORES cores, with LR/SC reservations.
// Optional feature: define DMEM_ARB_LRSC_EN to enable the per-core reservation registers.
module dmem_rr_arbiter #(
  parameter int unsigned NCORES     = 4,
  parameter int unsigned DMEM_ADDRW = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NCORES-1:0]          re_packed_i,
  input  logic [NCORES-1:0]          we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]       wdata_packed_i,
  input  logic [4*NCORES-1:0]        wstrb_packed_i,
  input  logic [NCORES-1:0]          is_lr_packed_i,
  input  logic [NCORES-1:0]          is_sc_packed_i,
  output logic [32*NCORES-1:0]       rdata_packed_o,
  output logic [NCORES-1:0]          stall_packed_o,
  output logic                       mem_re_o,
  output logic                       mem_we_o,
  output logic [DMEM_ADDRW-1:0]      mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  output logic [3:0]                 mem_wstrb_o,
  input  logic [31:0]                mem_rdata_i
);

  localparam int unsigned PW = $clog2(NCORES);
  localparam int unsigned AW = DMEM_ADDRW;

  logic [NCORES-1:0] req;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [PW-1:0]     cand;
  logic              grant;

  logic [AW-1:0]     addr_a  [NCORES];
  logic [31:0]       wdata_a [NCORES];
  logic [3:0]        wstrb_a [NCORES];

  logic              sel_re;
  logic              sel_we;
  logic              sel_sc;
  logic [AW-1:0]     sel_addr;
  logic              sc_ok;
  logic              do_write;

  logic              rsp_vld;
  logic [PW-1:0]     rsp_idx;
  logic              rsp_sc;
  logic              sc_fail;

  assign req = re_packed_i | we_packed_i;

  // Unpack per-core request slices
  always_comb begin
    for (int unsigned i = 0; i < NCORES; i++) begin
      addr_a[i]  = addr_packed_i[i*AW +: AW];
      wdata_a[i] = wdata_packed_i[i*32 +: 32];
      wstrb_a[i] = wstrb_packed_i[i*4 +: 4];
    end
  end

  // First requester at or after ptr wins; nothing is granted while in reset
  always_comb begin
    grant = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      cand = PW'((32'(ptr) + k) % NCORES);
      if (!rst_i && !grant && req[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
  end

  assign sel_re   = re_packed_i[win];
  assign sel_we   = we_packed_i[win];
  assign sel_sc   = is_sc_packed_i[win];
  assign sel_addr = addr_a[win];

`ifdef DMEM_ARB_LRSC_EN
  logic [NCORES-1:0] resv_vld;
  logic [AW-1:0]     resv_addr [NCORES];
  logic              sel_lr;

  assign sel_lr = is_lr_packed_i[win];
  assign sc_ok  = resv_vld[win] && (resv_addr[win] == sel_addr);

  // Reservation valid bits: set by LR, dropped by own SC or any write to the reserved word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resv_vld <= '0;
    end else begin
      for (int unsigned j = 0; j < NCORES; j++) begin
        if (do_write && (resv_addr[j] == sel_addr)) resv_vld[j] <= 1'b0;
      end
      if (grant && sel_re && sel_lr) resv_vld[win] <= 1'b1;
      if (grant && sel_we && sel_sc) resv_vld[win] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant && sel_re && sel_lr) resv_addr[win] <= sel_addr;
  end
`else
  logic unused_lr;
  assign unused_lr = ^is_lr_packed_i;
  assign sc_ok     = 1'b1;
`endif

  assign do_write = grant && sel_we && (!sel_sc || sc_ok);

  // BRAM port driven from the winning slice, zero when idle
  assign mem_re_o    = grant && sel_re;
  assign mem_we_o    = do_write;
  assign mem_addr_o  = grant ? sel_addr     : '0;
  assign mem_wdata_o = grant ? wdata_a[win] : '0;
  assign mem_wstrb_o = grant ? wstrb_a[win] : '0;

  always_comb begin
    for (int unsigned i = 0; i < NCORES; i++) begin
      stall_packed_o[i] = req[i] && !(grant && (win == PW'(i)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr     <= '0;
      rsp_vld <= 1'b0;
      rsp_idx <= '0;
      rsp_sc  <= 1'b0;
      sc_fail <= 1'b0;
    end else begin
      rsp_vld <= grant;
      rsp_idx <= win;
      rsp_sc  <= grant && sel_we && sel_sc;
      sc_fail <= !sc_ok;
      if (grant) ptr <= (win == PW'(NCORES - 1)) ? '0 : win + 1'b1;
    end
  end

  // Route last cycle's read data or SC status to the core granted last cycle
  always_comb begin
    for (int unsigned i = 0; i < NCORES; i++) begin
      rdata_packed_o[i*32 +: 32] = '0;
      if (rsp_vld && (rsp_idx == PW'(i))) begin
        rdata_packed_o[i*32 +: 32] = rsp_sc ? {31'b0, sc_fail} : mem_rdata_i;
      end
    end
  end

endmodule
